// File: rtl/parallel_register_pkg.sv
// Shared constants for the parallel-load register family.
package parallel_register_pkg;

    // Default data width of a register instance.
    localparam int PR_DEFAULT_WIDTH = 8;

    // Default value replicated into every bit on reset.
    localparam bit PR_DEFAULT_RESET = 1'b0;

endpackage : parallel_register_pkg

// File: rtl/pr_bit_cell.sv
// One storage bit: synchronous reset to RESET_BIT, load enable, otherwise hold.
module pr_bit_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    output logic q
);

    // Reset has priority over load; with neither asserted the flop holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pr_bit_cell

// File: rtl/parallel_load_register.sv
// Width-parameterised register with synchronous parallel load and hold.
// Built from x independent pr_bit_cell instances: bit i of q depends only on
// bit i of data_in and bit i of RESET_VALUE.
// Optional simulation checks are compiled in when PARALLEL_REG_ASSERT_EN is
// defined; the functional logic is identical either way.
module parallel_load_register
    import parallel_register_pkg::*;
#(
    parameter int           x           = PR_DEFAULT_WIDTH,
    parameter logic [x-1:0] RESET_VALUE = {x{PR_DEFAULT_RESET}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [x-1:0] data_in,
    output logic [x-1:0] q
);

    // One flop per bit; q comes straight from the flops.
    for (genvar i = 0; i < x; i++) begin : g_bit
        pr_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .d    (data_in[i]),
            .q    (q[i])
        );
    end

`ifdef PARALLEL_REG_ASSERT_EN
    // Reject a zero or negative width at elaboration.
    if (x < 1) begin : g_bad_width
        $error("parallel_load_register: width x must be at least 1");
    end

    // Flag unknown control or captured data at each rising edge.
    always @(posedge clk) begin
        if ($isunknown(rst)) begin
            $error("parallel_load_register: rst is X/Z at clock edge");
        end else if (!rst && $isunknown(load)) begin
            $error("parallel_load_register: load is X/Z while out of reset");
        end else if (!rst && load && $isunknown(data_in)) begin
            $error("parallel_load_register: data_in has X/Z bits during load");
        end
    end
`endif

endmodule : parallel_load_register

// File: tb/tb_parallel_load_register.sv
// Directed testbench for parallel_load_register at widths 8, 1 and 16.
module tb_parallel_load_register;

    // ---------------- clock / reset block ----------------
    logic clk;
    logic rst;
    logic load;
    logic [7:0]  data8;
    logic [0:0]  data1;
    logic [15:0] data16;
    logic [7:0]  q8;
    logic [0:0]  q1;
    logic [15:0] q16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    parallel_load_register #(.x(8)) dut8 (
        .clk (clk), .rst (rst), .load (load), .data_in (data8), .q (q8)
    );

    parallel_load_register #(.x(1)) dut1 (
        .clk (clk), .rst (rst), .load (load), .data_in (data1), .q (q1)
    );

    parallel_load_register #(.x(16)) dut16 (
        .clk (clk), .rst (rst), .load (load), .data_in (data16), .q (q16)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs, then let one rising edge pass and settle.
    task automatic cycle(input logic r, input logic l, input logic [7:0] d8,
                         input logic d1, input logic [15:0] d16);
        rst    = r;
        load   = l;
        data8  = d8;
        data1  = d1;
        data16 = d16;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; load = 1'b0; data8 = '0; data1 = '0; data16 = '0;

        // Reset for two cycles.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("reset_q8",  {8'h00, q8},  16'h0000);
        check("reset_q1",  {15'h0, q1},  16'h0000);
        check("reset_q16", q16,          16'h0000);

        // Single-cycle load pulse, including the narrow and wide instances.
        cycle(1'b0, 1'b1, 8'hB6, 1'b1, 16'hDEAD);
        check("load_q8",  {8'h00, q8}, 16'h00B6);
        check("load_q1",  {15'h0, q1}, 16'h0001);
        check("load_q16", q16,         16'hDEAD);
        cycle(1'b0, 1'b0, 8'hB6, 1'b0, 16'h0000);
        check("pulse_hold_q8",  {8'h00, q8}, 16'h00B6);
        check("pulse_hold_q1",  {15'h0, q1}, 16'h0001);
        check("pulse_hold_q16", q16,         16'hDEAD);

        // Data changes without load must not reach q.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 8'h55, 1'b0, 16'h1234);
            check("hold_q8",  {8'h00, q8}, 16'h00B6);
            check("hold_q16", q16,         16'hDEAD);
        end

        // Reset beats load in the same cycle.
        cycle(1'b1, 1'b1, 8'hFF, 1'b1, 16'hFFFF);
        check("prio_q8",  {8'h00, q8}, 16'h0000);
        check("prio_q1",  {15'h0, q1}, 16'h0000);
        check("prio_q16", q16,         16'h0000);

        // Back-to-back loads directly after reset release: no dead cycle.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1, 16'h0F0F);
        check("b2b0_q8",  {8'h00, q8}, 16'h00A5);
        check("b2b0_q16", q16,         16'h0F0F);
        cycle(1'b0, 1'b1, 8'h3C, 1'b0, 16'hBEEF);
        check("b2b1_q8",  {8'h00, q8}, 16'h003C);
        check("b2b1_q1",  {15'h0, q1}, 16'h0000);
        check("b2b1_q16", q16,         16'hBEEF);
        cycle(1'b0, 1'b1, 8'hFF, 1'b1, 16'h8001);
        check("b2b2_q8",  {8'h00, q8}, 16'h00FF);
        check("b2b2_q1",  {15'h0, q1}, 16'h0001);
        check("b2b2_q16", q16,         16'h8001);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("b2b_hold_q8",  {8'h00, q8}, 16'h00FF);
        check("b2b_hold_q16", q16,         16'h8001);

        // Reset between loads discards the stored word.
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 16'h7777);
        check("mid_reset_q8",  {8'h00, q8}, 16'h0000);
        check("mid_reset_q1",  {15'h0, q1}, 16'h0000);
        check("mid_reset_q16", q16,         16'h0000);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parallel_load_register
